// File: rtl/axi_mm_link_pkg.sv
// Link word layouts shared by the master and slave ends of the AXI memory-mapped link.
// Packed structs list fields MSB first, so the id field sits at bit 0 of every word.
package axi_mm_link_pkg;

  localparam int ID_W    = 4;
  localparam int SIZE_W  = 3;
  localparam int LEN_W   = 8;
  localparam int BURST_W = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int STRB_W  = 8;
  localparam int RESP_W  = 2;

  localparam int AX_ID_LSB    = 0;
  localparam int AX_SIZE_LSB  = 4;
  localparam int AX_LEN_LSB   = 7;
  localparam int AX_BURST_LSB = 15;
  localparam int AX_ADDR_LSB  = 17;
  localparam int W_LAST_BIT   = 76;
  localparam int R_LAST_BIT   = 68;

  localparam int AX_WORD_W = 49;
  localparam int W_WORD_W  = 77;
  localparam int R_WORD_W  = 71;
  localparam int B_WORD_W  = 6;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burst;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [ID_W-1:0]    id;
  } ax_word_t;

  typedef struct packed {
    logic              last;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } w_word_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic              last;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } r_word_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic [ID_W-1:0]   id;
  } b_word_t;

endpackage

// File: rtl/axi_mm_skid_buf.sv
// Two-entry register slice: ready and valid both come straight from flops, so no
// combinational path crosses it in either direction while still sustaining one beat per cycle.
module axi_mm_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [1:0][WIDTH-1:0] mem_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  in_ready_q, out_valid_q;
  logic                  push, pop;

  assign push        = in_valid_i & in_ready_q;
  assign pop         = out_valid_q & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Flags are registered from the next occupancy, so both track the entry count with no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
      wr_ptr_q    <= wr_ptr_q ^ push;
      rd_ptr_q    <= rd_ptr_q ^ pop;
      cnt_q       <= cnt_d;
      in_ready_q  <= (cnt_d != 2'd2);
      out_valid_q <= (cnt_d != 2'd0);
    end
  end

endmodule

// File: rtl/axi_mm_master_regslice.sv
// Master-end AXI4 link adapter: packs AR/AW/W onto link words, unpacks R/B, registers every
// channel through a skid buffer and bounds outstanding read and write bursts.
module axi_mm_master_regslice
  import axi_mm_link_pkg::*;
#(
  parameter int MAX_RD_OUTST = 8,
  parameter int MAX_WR_OUTST = 8
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic [3:0]           user_arid,
  input  logic [2:0]           user_arsize,
  input  logic [7:0]           user_arlen,
  input  logic [1:0]           user_arburst,
  input  logic [31:0]          user_araddr,
  input  logic                 user_arvalid,
  output logic                 user_arready,
  input  logic [3:0]           user_awid,
  input  logic [2:0]           user_awsize,
  input  logic [7:0]           user_awlen,
  input  logic [1:0]           user_awburst,
  input  logic [31:0]          user_awaddr,
  input  logic                 user_awvalid,
  output logic                 user_awready,
  input  logic [3:0]           user_wid,
  input  logic [63:0]          user_wdata,
  input  logic [7:0]           user_wstrb,
  input  logic                 user_wlast,
  input  logic                 user_wvalid,
  output logic                 user_wready,
  output logic [3:0]           user_rid,
  output logic [63:0]          user_rdata,
  output logic                 user_rlast,
  output logic [1:0]           user_rresp,
  output logic                 user_rvalid,
  input  logic                 user_rready,
  output logic [3:0]           user_bid,
  output logic [1:0]           user_bresp,
  output logic                 user_bvalid,
  input  logic                 user_bready,
  output logic                 user_ar_vld,
  output logic [AX_WORD_W-1:0] txfifo_ar_data,
  input  logic                 user_ar_ready,
  output logic                 user_aw_vld,
  output logic [AX_WORD_W-1:0] txfifo_aw_data,
  input  logic                 user_aw_ready,
  output logic                 user_w_vld,
  output logic [W_WORD_W-1:0]  txfifo_w_data,
  input  logic                 user_w_ready,
  input  logic                 user_r_vld,
  input  logic [R_WORD_W-1:0]  rxfifo_r_data,
  output logic                 user_r_ready,
  input  logic                 user_b_vld,
  input  logic [B_WORD_W-1:0]  rxfifo_b_data,
  output logic                 user_b_ready,
  output logic                 rd_underflow,
  output logic                 wr_underflow
);

  localparam int RD_CW = $clog2(MAX_RD_OUTST + 1);
  localparam int WR_CW = $clog2(MAX_WR_OUTST + 1);
  localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_OUTST);
  localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_OUTST);

  ax_word_t ar_in, aw_in;
  w_word_t  w_in;
  r_word_t  r_out;
  b_word_t  b_out;
  logic     ar_rdy, aw_rdy, rd_ok, wr_ok;

  assign ar_in = '{addr: user_araddr, burst: user_arburst, len: user_arlen,
                   size: user_arsize, id: user_arid};
  assign aw_in = '{addr: user_awaddr, burst: user_awburst, len: user_awlen,
                   size: user_awsize, id: user_awid};
  assign w_in  = '{last: user_wlast, strb: user_wstrb, data: user_wdata, id: user_wid};

  assign user_rid   = r_out.id;
  assign user_rdata = r_out.data;
  assign user_rlast = r_out.last;
  assign user_rresp = r_out.resp;
  assign user_bid   = b_out.id;
  assign user_bresp = b_out.resp;

  // Address channels are gated by the outstanding limit; W is left free so data may lead AW.
  assign user_arready = ar_rdy & rd_ok;
  assign user_awready = aw_rdy & wr_ok;

  axi_mm_skid_buf #(.WIDTH(AX_WORD_W)) u_ar (
    .clk_i(clk_wr), .rst_ni(rst_wr_n),
    .in_valid_i(user_arvalid & rd_ok), .in_ready_o(ar_rdy), .in_data_i(ar_in),
    .out_valid_o(user_ar_vld), .out_ready_i(user_ar_ready), .out_data_o(txfifo_ar_data));

  axi_mm_skid_buf #(.WIDTH(AX_WORD_W)) u_aw (
    .clk_i(clk_wr), .rst_ni(rst_wr_n),
    .in_valid_i(user_awvalid & wr_ok), .in_ready_o(aw_rdy), .in_data_i(aw_in),
    .out_valid_o(user_aw_vld), .out_ready_i(user_aw_ready), .out_data_o(txfifo_aw_data));

  axi_mm_skid_buf #(.WIDTH(W_WORD_W)) u_w (
    .clk_i(clk_wr), .rst_ni(rst_wr_n),
    .in_valid_i(user_wvalid), .in_ready_o(user_wready), .in_data_i(w_in),
    .out_valid_o(user_w_vld), .out_ready_i(user_w_ready), .out_data_o(txfifo_w_data));

  axi_mm_skid_buf #(.WIDTH(R_WORD_W)) u_r (
    .clk_i(clk_wr), .rst_ni(rst_wr_n),
    .in_valid_i(user_r_vld), .in_ready_o(user_r_ready), .in_data_i(rxfifo_r_data),
    .out_valid_o(user_rvalid), .out_ready_i(user_rready), .out_data_o(r_out));

  axi_mm_skid_buf #(.WIDTH(B_WORD_W)) u_b (
    .clk_i(clk_wr), .rst_ni(rst_wr_n),
    .in_valid_i(user_b_vld), .in_ready_o(user_b_ready), .in_data_i(rxfifo_b_data),
    .out_valid_o(user_bvalid), .out_ready_i(user_bready), .out_data_o(b_out));

  logic [RD_CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [WR_CW-1:0] wr_cnt_q, wr_cnt_d;
  logic             rd_inc, rd_dec, wr_inc, wr_dec;
  logic             rd_uf_q, rd_uf_d, wr_uf_q, wr_uf_d;

  assign rd_ok  = (rd_cnt_q < RD_MAX);
  assign wr_ok  = (wr_cnt_q < WR_MAX);
  assign rd_inc = user_arvalid & user_arready;
  assign rd_dec = user_rvalid & user_rready & user_rlast;
  assign wr_inc = user_awvalid & user_awready;
  assign wr_dec = user_bvalid & user_bready;
  assign rd_underflow = rd_uf_q;
  assign wr_underflow = wr_uf_q;

  // A close with nothing open saturates at zero and latches the underflow flag.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_uf_d  = rd_uf_q;
    if (rd_inc && !rd_dec) begin
      rd_cnt_d = rd_cnt_q + RD_CW'(1);
    end else if (rd_dec && !rd_inc) begin
      if (rd_cnt_q == '0) rd_uf_d = 1'b1;
      else                rd_cnt_d = rd_cnt_q - RD_CW'(1);
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_uf_d  = wr_uf_q;
    if (wr_inc && !wr_dec) begin
      wr_cnt_d = wr_cnt_q + WR_CW'(1);
    end else if (wr_dec && !wr_inc) begin
      if (wr_cnt_q == '0) wr_uf_d = 1'b1;
      else                wr_cnt_d = wr_cnt_q - WR_CW'(1);
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rd_uf_q  <= 1'b0;
      wr_uf_q  <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_uf_q  <= rd_uf_d;
      wr_uf_q  <= wr_uf_d;
    end
  end

endmodule
